// File: rtl/sound_cmd_tx.sv
// Main-board sound command transmitter: FIFO-queued 6-bit commands driven active-low
// for HOLD cycles, then idle for GAP cycles. Optional SOUND_CMD_TX_DEDUP_EN drops repeats.
module sound_cmd_tx #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned HOLD  = 2048,
    parameter int unsigned GAP   = 512
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr,
    input  logic [7:0]               din,
    input  logic                     ovf_clr,
    output logic [5:0]               ip2720,
    output logic                     busy,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int unsigned PtrW   = $clog2(DEPTH);
    localparam int unsigned LvlW   = $clog2(DEPTH) + 1;
    localparam int unsigned MaxCnt = (HOLD > GAP) ? HOLD : GAP;
    localparam int unsigned CntW   = $clog2(MaxCnt) + 1;

    localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD - 1);
    localparam logic [CntW-1:0] GapLoad  = CntW'(GAP - 1);
    localparam logic [LvlW-1:0] DepthLvl = LvlW'(DEPTH);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StHold = 2'd1;
    localparam logic [1:0] StGap  = 2'd2;

    logic [5:0]      mem [DEPTH];
    logic [PtrW-1:0] rptr_q, rptr_d;
    logic [PtrW-1:0] wptr_q, wptr_d;
    logic [LvlW-1:0] count_q, count_d;
    logic [1:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [5:0]      ip_q, ip_d;
    logic            ovf_q, ovf_d;

    logic [5:0] cmd;
    logic       cmd_valid;
    logic       fifo_empty;
    logic       pop;
    logic       push;
    logic       dedup_hit;
    logic       drop_full;

    assign cmd        = din[5:0];
    assign cmd_valid  = wr && (cmd != 6'd0);
    assign fifo_empty = (count_q == '0);

    // Pop when idle with work queued, or at the end of a gap with more queued.
    always_comb begin
        pop = 1'b0;
        if (!fifo_empty) begin
            if (state_q == StIdle) begin
                pop = 1'b1;
            end else if (state_q == StGap && cnt_q == '0) begin
                pop = 1'b1;
            end
        end
    end

`ifdef SOUND_CMD_TX_DEDUP_EN
    logic [PtrW-1:0] last_ptr;
    logic            last_live;

    assign last_ptr = wptr_q - 1'b1;
    // The newest entry is popped last, so it is still queued unless the FIFO drains now.
    assign last_live = (count_q > (pop ? LvlW'(1) : LvlW'(0)));
    assign dedup_hit = last_live && (mem[last_ptr] == cmd);
`else
    assign dedup_hit = 1'b0;
`endif

    assign drop_full = cmd_valid && !dedup_hit && (count_q == DepthLvl) && !pop;
    assign push      = cmd_valid && !dedup_hit && !drop_full;

    always_comb begin
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (drop_full) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ip_d    = ip_q;

        case (state_q)
            StIdle: begin
                if (pop) begin
                    ip_d    = ~mem[rptr_q];
                    cnt_d   = HoldLoad;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (cnt_q == '0) begin
                    ip_d    = 6'h3F;
                    cnt_d   = GapLoad;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    if (pop) begin
                        ip_d    = ~mem[rptr_q];
                        cnt_d   = HoldLoad;
                        state_d = StHold;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                ip_d    = 6'h3F;
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= '0;
            ip_q    <= 6'h3F;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ip_q    <= ip_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= cmd;
        end
    end

    assign ip2720   = ip_q;
    assign level    = count_q;
    assign full     = (count_q == DepthLvl);
    assign overflow = ovf_q;
    assign busy     = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_sound_cmd_tx.sv
// Directed bench for sound_cmd_tx with HOLD=4, GAP=2, DEPTH=4.
// Expectations follow SOUND_CMD_TX_DEDUP_EN when that macro is defined.
module tb_sound_cmd_tx;

    logic       clk;
    logic       reset;
    logic       wr;
    logic [7:0] din;
    logic       ovf_clr;
    logic [5:0] ip2720;
    logic       busy;
    logic       full;
    logic [2:0] level;
    logic       overflow;

    int checks;
    int failures;

    sound_cmd_tx #(
        .DEPTH (4),
        .HOLD  (4),
        .GAP   (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr       (wr),
        .din      (din),
        .ovf_clr  (ovf_clr),
        .ip2720   (ip2720),
        .busy     (busy),
        .full     (full),
        .level    (level),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle to the falling edge for sampling and driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic expect_ip(input string tag, input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, {26'd0, ip2720}, {26'd0, v});
        end
    endtask

    task automatic write(input logic [7:0] d);
        wr  = 1'b1;
        din = d;
        step();
        wr  = 1'b0;
        din = 8'h00;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        wr       = 1'b0;
        din      = 8'h00;
        ovf_clr  = 1'b0;
        @(negedge clk);

        // Reset
        step();
        step();
        reset = 1'b1;
        check("rst_ip", {26'd0, ip2720}, 32'h3F);
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        step();
        step();

        // Single command
        write(8'h05);
        check("single_level", {29'd0, level}, 32'd1);
        check("single_ip0", {26'd0, ip2720}, 32'h3F);
        check("single_busy0", {31'd0, busy}, 32'd1);
        expect_ip("single_hold", 6'h3A, 4);
        expect_ip("single_gap", 6'h3F, 2);
        check("single_busy_gap", {31'd0, busy}, 32'd1);
        step();
        check("single_busy_end", {31'd0, busy}, 32'd0);
        check("single_ip_end", {26'd0, ip2720}, 32'h3F);

        // Back-to-back
        write(8'h01);
        check("b2b_level0", {29'd0, level}, 32'd1);
        write(8'h02);
        check("b2b_ip1", {26'd0, ip2720}, 32'h3E);
        check("b2b_level1", {29'd0, level}, 32'd1);
        expect_ip("b2b_hold1", 6'h3E, 3);
        expect_ip("b2b_gap1", 6'h3F, 2);
        expect_ip("b2b_hold2", 6'h3D, 1);
        check("b2b_level2", {29'd0, level}, 32'd0);
        expect_ip("b2b_hold2", 6'h3D, 3);
        expect_ip("b2b_gap2", 6'h3F, 2);
        step();
        check("b2b_busy_end", {31'd0, busy}, 32'd0);

        // Overflow burst
        for (int i = 1; i <= 6; i++) begin
            write(8'(i));
            if (i == 4) check("ovf_not_yet", {31'd0, overflow}, 32'd0);
        end
        check("ovf_set", {31'd0, overflow}, 32'd1);
        check("ovf_full", {31'd0, full}, 32'd1);
        check("ovf_level", {29'd0, level}, 32'd4);
        check("ovf_ip_gap", {26'd0, ip2720}, 32'h3F);
        expect_ip("ovf_gap1", 6'h3F, 1);
        for (int c = 2; c <= 5; c++) begin
            expect_ip("ovf_hold", ~6'(c), 4);
            expect_ip("ovf_gap", 6'h3F, 2);
        end
        step();
        check("ovf_busy_end", {31'd0, busy}, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Zero command and reset abort
        write(8'h40);
        check("zero_level", {29'd0, level}, 32'd0);
        check("zero_busy", {31'd0, busy}, 32'd0);
        check("zero_ip", {26'd0, ip2720}, 32'h3F);
        write(8'h3F);
        check("abort_level", {29'd0, level}, 32'd1);
        expect_ip("abort_hold", 6'h00, 2);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort_ip", {26'd0, ip2720}, 32'h3F);
        check("abort_level0", {29'd0, level}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        step();
        check("abort_ip_after", {26'd0, ip2720}, 32'h3F);

        // Repeated command while the first copy is still queued
        write(8'h01);
        step();
        check("dup_ip0", {26'd0, ip2720}, 32'h3E);
        write(8'h07);
        write(8'h07);
`ifdef SOUND_CMD_TX_DEDUP_EN
        check("dup_level", {29'd0, level}, 32'd1);
`else
        check("dup_level", {29'd0, level}, 32'd2);
`endif
        check("dup_ovf", {31'd0, overflow}, 32'd0);
        check("dup_ip1", {26'd0, ip2720}, 32'h3E);
        expect_ip("dup_hold0", 6'h3E, 1);
        expect_ip("dup_gap0", 6'h3F, 2);
        expect_ip("dup_hold1", 6'h38, 4);
        expect_ip("dup_gap1", 6'h3F, 2);
`ifndef SOUND_CMD_TX_DEDUP_EN
        expect_ip("dup_hold2", 6'h38, 4);
        expect_ip("dup_gap2", 6'h3F, 2);
`endif
        step();
        check("dup_busy_end", {31'd0, busy}, 32'd0);
        check("dup_ip_end", {26'd0, ip2720}, 32'h3F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
